// File: rtl/regfile_write_arbiter_pkg.sv
// Shared defaults and the holding-buffer entry type for the register file write arbiter.
// The arbitration mode is selected by REGFILE_ARB_FIXED_PRIO_EN (see rr_arbiter).
package regfile_arb_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 3;
    localparam int DEFAULT_REG_WIDTH  = 16;
    localparam int DEFAULT_N_REQ      = 3;

    typedef struct packed {
        logic                          full;
        logic [DEFAULT_ADDR_WIDTH-1:0] addr;
        logic [DEFAULT_REG_WIDTH-1:0]  data;
    } wr_entry_t;

    // Builds an occupied entry from an address/data pair.
    function automatic wr_entry_t mk_entry(input logic [DEFAULT_ADDR_WIDTH-1:0] addr,
                                           input logic [DEFAULT_REG_WIDTH-1:0]  data);
        wr_entry_t e;
        e.full = 1'b1;
        e.addr = addr;
        e.data = data;
        return e;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Requester handshake, register file write port and pending bitmap of the write arbiter.
// The slave modport is the arbiter's view; master is the requester/register-file side.
interface regfile_write_arbiter_if #(
    parameter int ADDR_WIDTH = regfile_arb_pkg::DEFAULT_ADDR_WIDTH,
    parameter int REG_WIDTH  = regfile_arb_pkg::DEFAULT_REG_WIDTH,
    parameter int N_REQ      = regfile_arb_pkg::DEFAULT_N_REQ
);
    localparam int REG_N = 2**ADDR_WIDTH;

    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ-1:0]            req_ready;
    logic [N_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [N_REQ*REG_WIDTH-1:0]  req_data;
    logic [ADDR_WIDTH-1:0]       write_addr;
    logic [REG_WIDTH-1:0]        write_bus;
    logic                        write_enabled;
    logic [N_REQ-1:0]            grant_onehot;
    logic [REG_N-1:0]            pending;

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, write_addr, write_bus, write_enabled, grant_onehot, pending
    );

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, write_addr, write_bus, write_enabled, grant_onehot, pending
    );

endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Single-grant arbiter over N requests: round-robin by default, fixed priority
// (index 0 highest, no pointer state) when REGFILE_ARB_FIXED_PRIO_EN is defined.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req_i,
    input  logic         advance_i,
    output logic [N-1:0] grant_o
);

`ifdef REGFILE_ARB_FIXED_PRIO_EN

    logic unused_s;
    logic found_s;

    assign unused_s = clk ^ reset ^ advance_i;

    // Lowest-index request wins.
    always_comb begin
        grant_o = '0;
        found_s = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found_s && req_i[k]) begin
                grant_o[k] = 1'b1;
                found_s    = 1'b1;
            end else begin
                grant_o[k] = 1'b0;
            end
        end
    end

`else

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] win_s;
    logic [PW:0]   cand_s;
    logic          found_s;

    // Search rr_ptr, rr_ptr+1, ... modulo N; the extra bit lets the sum wrap for non-power-of-two N.
    always_comb begin
        grant_o = '0;
        found_s = 1'b0;
        win_s   = ptr_q;
        cand_s  = '0;
        for (int k = 0; k < N; k++) begin
            cand_s = {1'b0, ptr_q} + (PW+1)'(k);
            if (cand_s >= (PW+1)'(N)) begin
                cand_s = cand_s - (PW+1)'(N);
            end else begin
                cand_s = cand_s;
            end
            if (!found_s && req_i[cand_s[PW-1:0]]) begin
                found_s = 1'b1;
                win_s   = cand_s[PW-1:0];
            end else begin
                found_s = found_s;
            end
        end
        if (found_s) begin
            grant_o[win_s] = 1'b1;
        end else begin
            grant_o = '0;
        end
    end

    // Pointer moves just past the winner; holds when nothing is granted.
    always_comb begin
        ptr_d = ptr_q;
        if (advance_i && found_s) begin
            if (win_s == PW'(N-1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = win_s + PW'(1);
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Priority pointer register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

`endif

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port among N_REQ sources via one-entry buffers,
// a single-grant arbiter and a registered output stage. Mode macro: REGFILE_ARB_FIXED_PRIO_EN.
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int REG_WIDTH  = DEFAULT_REG_WIDTH,
    parameter int N_REQ      = DEFAULT_N_REQ
) (
    input  logic                   clk,
    input  logic                   reset,
    regfile_write_arbiter_if.slave bus
);

    localparam int REG_N = 2**ADDR_WIDTH;

    logic [N_REQ-1:0]      full_q, full_d;
    logic [ADDR_WIDTH-1:0] addr_q [N_REQ];
    logic [ADDR_WIDTH-1:0] addr_d [N_REQ];
    logic [REG_WIDTH-1:0]  data_q [N_REQ];
    logic [REG_WIDTH-1:0]  data_d [N_REQ];

    logic [N_REQ-1:0]      grant_s, ready_s, accept_s;
    logic [ADDR_WIDTH-1:0] sel_addr_s;
    logic [REG_WIDTH-1:0]  sel_data_s;
    logic [REG_N-1:0]      pending_s;

    logic                  wen_q, wen_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [REG_WIDTH-1:0]  wdata_q, wdata_d;
    logic [N_REQ-1:0]      gnt_q, gnt_d;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req_i     (full_q),
        .advance_i (|grant_s),
        .grant_o   (grant_s)
    );

    // A granted buffer drains this edge, so it can take a new write on the same edge.
    assign ready_s  = ~full_q | grant_s;
    assign accept_s = bus.req_valid & ready_s;

    // Buffer next state: load on accept, otherwise empty on grant, otherwise hold.
    always_comb begin
        full_d = full_q;
        addr_d = addr_q;
        data_d = data_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (accept_s[i]) begin
                full_d[i] = 1'b1;
                addr_d[i] = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                data_d[i] = bus.req_data[i*REG_WIDTH +: REG_WIDTH];
            end else if (grant_s[i]) begin
                full_d[i] = 1'b0;
            end else begin
                full_d[i] = full_q[i];
            end
        end
    end

    // One-hot AND-OR mux of the granted buffer.
    always_comb begin
        sel_addr_s = '0;
        sel_data_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sel_addr_s = sel_addr_s | (addr_q[i] & {ADDR_WIDTH{grant_s[i]}});
            sel_data_s = sel_data_s | (data_q[i] & {REG_WIDTH{grant_s[i]}});
        end
    end

    // Output stage next state; address and data hold when idle.
    always_comb begin
        wen_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        gnt_d   = '0;
        if (|grant_s) begin
            wen_d   = 1'b1;
            waddr_d = sel_addr_s;
            wdata_d = sel_data_s;
            gnt_d   = grant_s;
        end else begin
            wen_d   = 1'b0;
            gnt_d   = '0;
        end
    end

    // Buffers and output stage registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            full_q  <= '0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            gnt_q   <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            full_q  <= full_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            gnt_q   <= gnt_d;
            for (int i = 0; i < N_REQ; i++) begin
                addr_q[i] <= addr_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

    // Decode stage stalls on any register still owed a write.
    always_comb begin
        pending_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (full_q[i]) begin
                pending_s[addr_q[i]] = 1'b1;
            end else begin
                pending_s = pending_s;
            end
        end
        if (wen_q) begin
            pending_s[waddr_q] = 1'b1;
        end else begin
            pending_s = pending_s;
        end
    end

    assign bus.req_ready     = ready_s;
    assign bus.write_addr    = waddr_q;
    assign bus.write_bus     = wdata_q;
    assign bus.write_enabled = wen_q;
    assign bus.grant_onehot  = gnt_q;
    assign bus.pending       = pending_s;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter; inputs change and outputs
// are sampled on the falling clock edge.
module tb_regfile_write_arbiter;
    import regfile_arb_pkg::*;

    logic clk;
    logic reset;
    int   err_cnt;
    int   chk_cnt;
    int   wr_cnt;
    logic [15:0] rf_model [8];

    regfile_write_arbiter_if bus ();

    regfile_write_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register file image and write counter, fed only by the DUT write port.
    always @(posedge clk) begin
        if (bus.write_enabled) begin
            rf_model[bus.write_addr] <= bus.write_bus;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input wr_entry_t e);
        bus.req_valid[i]          = e.full;
        bus.req_addr[i*3 +: 3]    = e.addr;
        bus.req_data[i*16 +: 16]  = e.data;
    endtask

    task automatic clr_req();
        bus.req_valid = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clr_req();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic wen, input logic [2:0] gnt,
                           input logic [2:0] a, input logic [15:0] d);
        chk_eq({tag, "_wen"}, 32'(bus.write_enabled), 32'(wen));
        chk_eq({tag, "_gnt"}, 32'(bus.grant_onehot), 32'(gnt));
        chk_eq({tag, "_addr"}, 32'(bus.write_addr), 32'(a));
        chk_eq({tag, "_data"}, 32'(bus.write_bus), 32'(d));
    endtask

    initial begin
        int w0;
        int grants;
        int seen_at;
        logic [15:0] seen_data;
        err_cnt = 0;
        chk_cnt = 0;
        wr_cnt  = 0;
        for (int r = 0; r < 8; r++) rf_model[r] = 16'h0000;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        reset = 1'b1;
        tick();
        tick();

        // Reset state
        chk_out("rst", 1'b0, 3'b000, 3'd0, 16'h0000);
        chk_eq("rst_ready", 32'(bus.req_ready), 32'h7);
        chk_eq("rst_pend", 32'(bus.pending), 32'h0);
        reset = 1'b0;

        // Three requesters at once, granted 0,1,2
        set_req(0, mk_entry(3'd1, 16'h1111));
        set_req(1, mk_entry(3'd2, 16'h2222));
        set_req(2, mk_entry(3'd3, 16'h3333));
        tick();
        chk_eq("t1_pend0", 32'(bus.pending), 32'h0E);
        chk_eq("t1_ready0", 32'(bus.req_ready), 32'h1);
        chk_eq("t1_wen0", 32'(bus.write_enabled), 32'h0);
        clr_req();
        tick();
        chk_out("t1_w1", 1'b1, 3'b001, 3'd1, 16'h1111);
        chk_eq("t1_pend1", 32'(bus.pending), 32'h0E);
        tick();
        chk_out("t1_w2", 1'b1, 3'b010, 3'd2, 16'h2222);
        chk_eq("t1_pend2", 32'(bus.pending), 32'h0C);
        tick();
        chk_out("t1_w3", 1'b1, 3'b100, 3'd3, 16'h3333);
        chk_eq("t1_pend3", 32'(bus.pending), 32'h08);
        tick();
        chk_out("t1_idle", 1'b0, 3'b000, 3'd3, 16'h3333);
        chk_eq("t1_pend4", 32'(bus.pending), 32'h0);

        // Requester 1 streams three writes back to back
        set_req(1, mk_entry(3'd4, 16'h4444));
        tick();
        chk_eq("t2_ready_a", 32'(bus.req_ready[1]), 32'h1);
        chk_eq("t2_pend_a", 32'(bus.pending), 32'h10);
        set_req(1, mk_entry(3'd5, 16'h5555));
        tick();
        chk_out("t2_w4", 1'b1, 3'b010, 3'd4, 16'h4444);
        chk_eq("t2_ready_b", 32'(bus.req_ready[1]), 32'h1);
        set_req(1, mk_entry(3'd6, 16'h6666));
        tick();
        chk_out("t2_w5", 1'b1, 3'b010, 3'd5, 16'h5555);
        chk_eq("t2_ready_c", 32'(bus.req_ready[1]), 32'h1);
        clr_req();
        tick();
        chk_out("t2_w6", 1'b1, 3'b010, 3'd6, 16'h6666);
        tick();
        chk_eq("t2_idle", 32'(bus.write_enabled), 32'h0);

        // Same address from requesters 0 and 2 with rr_ptr = 0
        do_reset();
        set_req(0, mk_entry(3'd7, 16'hAAAA));
        set_req(2, mk_entry(3'd7, 16'hBBBB));
        tick();
        clr_req();
        tick();
        chk_out("t3_first", 1'b1, 3'b001, 3'd7, 16'hAAAA);
        tick();
        chk_out("t3_second", 1'b1, 3'b100, 3'd7, 16'hBBBB);
        tick();
        chk_eq("t3_rf7", 32'(rf_model[7]), 32'hBBBB);

        // Requester 0 hammers while requester 2 waits
        set_req(0, mk_entry(3'd0, 16'h0F0F));
        set_req(2, mk_entry(3'd5, 16'h5A5A));
        tick();
        bus.req_valid[2] = 1'b0;
        grants    = 0;
        seen_at   = 0;
        seen_data = 16'h0000;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (bus.write_enabled) begin
                grants++;
                if (bus.grant_onehot == 3'b100 && seen_at == 0) begin
                    seen_at   = grants;
                    seen_data = bus.write_bus;
                end
            end
        end
        clr_req();
`ifdef REGFILE_ARB_FIXED_PRIO_EN
        chk_eq("t4_starved", 32'(seen_at), 32'd0);
`else
        chk_eq("t4_rr_grant_no", 32'(seen_at), 32'd2);
        chk_eq("t4_rr_data", 32'(seen_data), 32'h5A5A);
`endif
        repeat (3) tick();
        chk_eq("t4_drained_wen", 32'(bus.write_enabled), 32'h0);
        chk_eq("t4_drained_pend", 32'(bus.pending), 32'h0);

        // Reset with two buffers full and the output stage busy
        do_reset();
        set_req(0, mk_entry(3'd1, 16'h1234));
        set_req(1, mk_entry(3'd2, 16'h2345));
        set_req(2, mk_entry(3'd3, 16'h3456));
        tick();
        clr_req();
        tick();
        chk_eq("t5_busy", 32'(bus.write_enabled), 32'h1);
        reset = 1'b1;
        tick();
        chk_eq("t5_wen", 32'(bus.write_enabled), 32'h0);
        chk_eq("t5_pend", 32'(bus.pending), 32'h0);
        chk_eq("t5_ready", 32'(bus.req_ready), 32'h7);
        reset = 1'b0;
        w0 = wr_cnt;
        repeat (4) tick();
        chk_eq("t5_no_writes", 32'(wr_cnt - w0), 32'd0);

        // Buffer 1 reloaded on the edge it is granted
        w0 = wr_cnt;
        set_req(1, mk_entry(3'd4, 16'h4A4A));
        tick();
        chk_eq("t6_ready1", 32'(bus.req_ready[1]), 32'h1);
        set_req(1, mk_entry(3'd6, 16'h6B6B));
        tick();
        chk_out("t6_w_first", 1'b1, 3'b010, 3'd4, 16'h4A4A);
        clr_req();
        tick();
        chk_out("t6_w_second", 1'b1, 3'b010, 3'd6, 16'h6B6B);
        tick();
        chk_eq("t6_idle", 32'(bus.write_enabled), 32'h0);
        chk_eq("t6_count", 32'(wr_cnt - w0), 32'd2);
        chk_eq("t6_rf4", 32'(rf_model[4]), 32'h4A4A);
        chk_eq("t6_rf6", 32'(rf_model[6]), 32'h6B6B);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register file's single write port (write_addr / write_bus / write_enabled) among N_REQ independent writeback sources, such as the ALU, the load path and the immediate loader. Each source hands off through a valid/ready handshake into a one-entry holding buffer. A round-robin arbiter drains one buffered write per cycle into a registered output stage that drives the register file directly. A per-register pending bitmap is exported so the decode stage can stall on read-after-write hazards.

## Interface
Parameters:
- ADDR_WIDTH, 3, register address width; REG_N = 2**ADDR_WIDTH
- REG_WIDTH, 16, data width
- N_REQ, 3, number of write requesters (2..8)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  N_REQ  per-requester write request
- req_ready  out  N_REQ  per-requester buffer can accept
- req_addr  in  N_REQ*ADDR_WIDTH  packed target addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_data  in  N_REQ*REG_WIDTH  packed write data; requester i at [i*REG_WIDTH +: REG_WIDTH]
- write_addr  out  ADDR_WIDTH  register file write address (registered)
- write_bus  out  REG_WIDTH  register file write data (registered)
- write_enabled  out  1  register file write strobe (registered)
- grant_onehot  out  N_REQ  requester whose write is on the port this cycle (registered)
- pending  out  REG_N  bit a = 1 while any buffer or the output stage holds a write to register a

## Operation
- Holding buffer i stores {full, addr, data}.
- Transfer into buffer i occurs when req_valid[i] && req_ready[i].
- req_ready[i] = ~full[i] | grant[i]. A buffer granted this cycle can be reloaded on the same edge.
- Arbiter candidates are the buffers with full[i] = 1. At most one grant per cycle.
- Round-robin priority:
  - rr_ptr is the highest-priority index; search order is rr_ptr, rr_ptr+1, … mod N_REQ.
  - After a grant to i, rr_ptr <= (i+1) mod N_REQ.
  - With no grant, rr_ptr holds.
- On grant, the output stage loads write_addr, write_bus and grant_onehot from buffer i and sets write_enabled = 1. With no grant, write_enabled = 0 and grant_onehot = 0; write_addr and write_bus hold their last values.
- Clearing full[i] and loading the output stage happen on the same edge.
- pending is combinational: OR over the decoded addresses of all full buffers and of the output stage when write_enabled = 1.
- Several requesters targeting the same address are written in grant order. No cross-requester ordering is guaranteed. Within one requester, order is preserved.
- Reset:
  - full = 0, rr_ptr = 0
  - write_enabled = 0, write_addr = 0, write_bus = 0, grant_onehot = 0
  - req_ready = all ones
- A reset during operation discards all buffered writes. No partial write reaches the register file.

## Timing
- Accept at edge E0. The earliest grant is in the cycle after E0. The output stage is valid after E1. The register file captures the write at E2.
- Minimum accept-to-register-update latency: 2 edges.
- Throughput: 1 write per cycle aggregate; 1 per cycle for a single uncontended requester.
- Worst-case wait for a full buffer: N_REQ-1 grants.
- req_ready depends combinationally on the current grant only, not on req_valid. There is no combinational path from req_valid to req_ready.
- pending[a] rises the cycle after the accept edge. It falls in the cycle after the register file write edge, when the output stage is empty or holds a different address.

## Configuration
- REGFILE_ARB_FIXED_PRIO_EN defined: fixed priority, with requester 0 highest. rr_ptr is not implemented and the search always starts at index 0. A low-index requester can starve higher indices.
- Not defined: round-robin as described above.
- All other behaviour is identical in both modes.

## Structure
- Package regfile_arb_pkg holds:
  - default ADDR_WIDTH, REG_WIDTH, N_REQ
  - typedef wr_entry_t {logic full; logic [ADDR_WIDTH-1:0] addr; logic [REG_WIDTH-1:0] data;}
- Sub-module rr_arbiter (parameter N):
  - inputs: request vector, clk, reset, advance
  - output: one-hot grant
  - owns rr_ptr
  - fixed-priority mode under the macro
- The top level holds the buffers, the output stage and the pending decode.

## Test plan
- After reset, all three requesters hold req_valid with addrs 1/2/3 and data 0x1111/0x2222/0x3333 → write_enabled high for 3 consecutive cycles with grant_onehot 001, 010, 100, and pending = 0x0E until drained.
- Requester 1 alone streams addrs 4,5,6 back to back → req_ready stays 1 and one write per cycle appears 2 edges after each accept, in order.
- Requesters 0 and 2 both write addr 7 (0xAAAA, 0xBBBB) in the same cycle, with rr_ptr = 0 → 0xAAAA is written then 0xBBBB, leaving final register 7 = 0xBBBB.
- Requester 0 asserts continuously while requester 2 waits → requester 2 is granted within 2 grants (round-robin). With REGFILE_ARB_FIXED_PRIO_EN defined, requester 2 is never granted.
- Assert reset while two buffers are full and write_enabled = 1 → the next cycle shows write_enabled = 0, pending = 0, req_ready = 111, and no further writes occur.
- Buffer 1 is granted while req_valid[1] presents a new write in the same cycle → req_ready[1] = 1, and the new write is granted on a following cycle with no lost or duplicate write.
